// File: rtl/alu_cmd_engine.sv
// alu_cmd_engine: packet engine between the UART byte receiver and transmitter.
// Frames received bytes into [opcode][reserved][len_lo][len_hi][payload]
// packets, then echoes the payload or returns the 32-bit sum/product of the
// little-endian operands.
// Optional feature: define CMD_TIMEOUT_EN to abort a packet after
// TIMEOUT_CYCLES cycles without an rx transfer. Without it the engine waits
// indefinitely inside a packet.
module alu_cmd_engine #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned OPERAND_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 3225600
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  error_o,
  output logic                  busy_o
);

  localparam int unsigned BYTES = OPERAND_WIDTH / DATA_WIDTH;
  localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [DATA_WIDTH-1:0] OP_ECHO = DATA_WIDTH'(8'hEC);
  localparam logic [DATA_WIDTH-1:0] OP_ADD  = DATA_WIDTH'(8'hA0);
  localparam logic [DATA_WIDTH-1:0] OP_MUL  = DATA_WIDTH'(8'hA1);

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_ECHO,
    S_OPERAND,
    S_SEND,
    S_DRAIN
  } state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic                            r_run;        // low in reset, keeps rx_ready_o low
  logic [DATA_WIDTH-1:0]           r_opcode;
  logic [DATA_WIDTH-1:0]           r_len_lo;
  logic [15:0]                     r_remaining;
  logic [OPERAND_WIDTH-DATA_WIDTH-1:0] r_operand; // bytes collected so far, LSB first
  logic [OPERAND_WIDTH-1:0]        r_acc;
  logic [BCW-1:0]                  r_byte_cnt;   // byte position inside operand / result
  logic                            r_first;      // next completed operand seeds the accumulator
  logic                            r_error;

  logic                            w_rx_ready;
  logic                            w_tx_valid;
  logic [DATA_WIDTH-1:0]           w_tx_data;
  logic                            w_rx_fire;
  logic                            w_tx_fire;
  logic                            w_err_set;
  logic                            w_timeout;
  logic [15:0]                     w_len;
  logic [15:0]                     w_rem_init;
  logic                            w_rem_bad;
  logic                            w_is_echo;
  logic                            w_is_alu;
  logic                            w_last_byte;
  logic [OPERAND_WIDTH-1:0]        w_operand_full;
  logic [OPERAND_WIDTH-1:0]        w_acc_next;

  assign w_len          = {rx_data_i, r_len_lo};
  assign w_rem_init     = w_len - 16'd4;
  assign w_rem_bad      = (w_rem_init == 16'd0) || ((w_rem_init % 16'(BYTES)) != 16'd0);
  assign w_is_echo      = (r_opcode == OP_ECHO);
  assign w_is_alu       = (r_opcode == OP_ADD) || (r_opcode == OP_MUL);
  assign w_last_byte    = (r_byte_cnt == BCW'(BYTES - 1));
  assign w_operand_full = {rx_data_i, r_operand};
  assign w_rx_fire      = rx_valid_i & w_rx_ready;
  assign w_tx_fire      = w_tx_valid & tx_ready_i;

  // Accumulator update when an operand completes: seed, add or multiply (low bits kept)
  always_comb begin
    w_acc_next = w_operand_full;
    if (!r_first) begin
      if (r_opcode == OP_ADD) begin
        w_acc_next = r_acc + w_operand_full;
      end else begin
        w_acc_next = r_acc * w_operand_full;
      end
    end
  end

  // Stream handshake outputs per state; ECHO is a pure combinational passthrough
  always_comb begin
    w_rx_ready = 1'b0;
    w_tx_valid = 1'b0;
    w_tx_data  = '0;
    case (r_state)
      S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_OPERAND: begin
        w_rx_ready = r_run;
      end
      S_ECHO: begin
        w_rx_ready = tx_ready_i;
        w_tx_valid = rx_valid_i;
        w_tx_data  = rx_data_i;
      end
      S_SEND: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_acc[r_byte_cnt*DATA_WIDTH +: DATA_WIDTH];
      end
      S_DRAIN: begin
        w_rx_ready = (r_remaining != 16'd0);
      end
      default: begin
        w_rx_ready = 1'b0;
      end
    endcase
  end

  // Next-state decision and error pulse request
  always_comb begin
    w_state_next = r_state;
    w_err_set    = 1'b0;
    case (r_state)
      S_OPCODE:  if (w_rx_fire) w_state_next = S_RSVD;
      S_RSVD:    if (w_rx_fire) w_state_next = S_LEN_LO;
      S_LEN_LO:  if (w_rx_fire) w_state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_rx_fire) begin
          if (w_len < 16'd4) begin
            w_err_set    = 1'b1;
            w_state_next = S_OPCODE;
          end else if (!w_is_echo && !w_is_alu) begin
            w_err_set    = 1'b1;
            w_state_next = S_DRAIN;
          end else if (w_is_alu && w_rem_bad) begin
            w_err_set    = 1'b1;
            w_state_next = S_DRAIN;
          end else if (w_is_echo && (w_rem_init == 16'd0)) begin
            w_state_next = S_OPCODE;
          end else if (w_is_echo) begin
            w_state_next = S_ECHO;
          end else begin
            w_state_next = S_OPERAND;
          end
        end
      end
      S_ECHO:    if (w_rx_fire && (r_remaining == 16'd1)) w_state_next = S_OPCODE;
      S_OPERAND: if (w_rx_fire && (r_remaining == 16'd1)) w_state_next = S_SEND;
      S_SEND:    if (w_tx_fire && w_last_byte) w_state_next = S_OPCODE;
      S_DRAIN: begin
        if ((r_remaining == 16'd0) || (w_rx_fire && (r_remaining == 16'd1))) begin
          w_state_next = S_OPCODE;
        end
      end
      default:   w_state_next = S_OPCODE;
    endcase
    if (w_timeout) begin
      w_err_set    = 1'b1;
      w_state_next = S_OPCODE;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_OPCODE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Header capture, byte counters, operand shift and accumulator
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run       <= 1'b0;
      r_error     <= 1'b0;
      r_opcode    <= '0;
      r_len_lo    <= '0;
      r_remaining <= '0;
      r_operand   <= '0;
      r_acc       <= '0;
      r_byte_cnt  <= '0;
      r_first     <= 1'b1;
    end else begin
      r_run   <= 1'b1;
      r_error <= w_err_set;
      if (w_timeout) begin
        r_acc       <= '0;
        r_remaining <= '0;
        r_byte_cnt  <= '0;
        r_first     <= 1'b1;
      end else begin
        case (r_state)
          S_OPCODE: if (w_rx_fire) r_opcode <= rx_data_i;
          S_LEN_LO: if (w_rx_fire) r_len_lo <= rx_data_i;
          S_LEN_HI: begin
            if (w_rx_fire) begin
              r_remaining <= (w_len < 16'd4) ? 16'd0 : w_rem_init;
              r_byte_cnt  <= '0;
              r_first     <= 1'b1;
            end
          end
          S_ECHO, S_DRAIN: begin
            if (w_rx_fire && (r_remaining != 16'd0)) r_remaining <= r_remaining - 16'd1;
          end
          S_OPERAND: begin
            if (w_rx_fire) begin
              r_remaining <= r_remaining - 16'd1;
              r_operand   <= w_operand_full[OPERAND_WIDTH-1:DATA_WIDTH];
              if (w_last_byte) begin
                r_acc      <= w_acc_next;
                r_first    <= 1'b0;
                r_byte_cnt <= '0;
              end else begin
                r_byte_cnt <= r_byte_cnt + BCW'(1);
              end
            end
          end
          S_SEND: begin
            if (w_tx_fire) r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + BCW'(1);
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TOW-1:0] r_idle_cnt;
  logic           w_idle_track;

  // SEND is excluded: the transmitter, not the sender, is the one stalling there
  assign w_idle_track = (r_state != S_OPCODE) && (r_state != S_SEND);
  assign w_timeout    = w_idle_track && !w_rx_fire &&
                        (r_idle_cnt == TOW'(TIMEOUT_CYCLES - 1));

  // Idle counter: counts cycles without an rx transfer inside a packet
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idle_cnt <= '0;
    end else if (!w_idle_track || w_rx_fire || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + TOW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign rx_ready_o = w_rx_ready;
  assign tx_valid_o = w_tx_valid;
  assign tx_data_o  = w_tx_data;
  assign error_o    = r_error;
  assign busy_o     = (r_state != S_OPCODE);

endmodule

// File: tb/tb_alu_cmd_engine.sv
// tb_alu_cmd_engine: directed and randomized packets against a packet-level
// reference model; tx bytes and error pulses are collected by a monitor.
module tb_alu_cmd_engine;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready;
  logic       error_o;
  logic       busy_o;

  logic       bp_mode;
  logic       tx_ready_force;

  byte_q_t    q_tx;
  int         err_total = 0;
  int         n_checks  = 0;
  int         n_errors  = 0;

  alu_cmd_engine #(.TIMEOUT_CYCLES(100)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready),
    .error_o    (error_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  // tx_ready driver: random backpressure or a forced level
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : tx_ready_force;
    end
  end

  // Monitor: inputs change only at posedge+1, so negedge values are what the edge sees
  always @(negedge clk) begin
    if (rst_n && tx_valid_o && tx_ready) q_tx.push_back(tx_data_o);
    if (error_o) err_total <= err_total + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packet-level reference: expected tx bytes and number of error pulses
  function automatic void ref_model(input byte_q_t p, output byte_q_t exp, output int n_err);
    int len;
    int rem;
    logic [31:0] acc;
    logic [31:0] opnd;
    exp   = {};
    n_err = 0;
    acc   = 32'd0;
    len   = int'({p[3], p[2]});
    if (len < 4) begin
      n_err = 1;
      return;
    end
    rem = len - 4;
    case (p[0])
      8'hEC: for (int i = 4; i < len; i++) exp.push_back(p[i]);
      8'hA0, 8'hA1: begin
        if (rem == 0 || (rem % 4) != 0) begin
          n_err = 1;
        end else begin
          for (int k = 0; k < rem / 4; k++) begin
            opnd = {p[4*k+7], p[4*k+6], p[4*k+5], p[4*k+4]};
            if (k == 0) acc = opnd;
            else if (p[0] == 8'hA0) acc = acc + opnd;
            else acc = acc * opnd;
          end
          for (int b = 0; b < 4; b++) exp.push_back(acc[8*b +: 8]);
        end
      end
      default: n_err = 1;
    endcase
  endfunction

  function automatic byte_q_t make_random();
    byte_q_t p;
    int kind;
    int len;
    int r;
    logic [7:0] op;
    p    = {};
    kind = int'($urandom_range(0, 5));
    case (kind)
      0: begin op = 8'hEC; len = 4 + int'($urandom_range(0, 8)); end
      1: begin op = 8'hA0; len = 4 + 4 * int'($urandom_range(1, 4)); end
      2: begin op = 8'hA1; len = 4 + 4 * int'($urandom_range(1, 3)); end
      3: begin
        op  = ($urandom_range(0, 1) == 0) ? 8'hA0 : 8'hA1;
        r   = int'($urandom_range(0, 6));
        len = 4 + ((r < 4) ? r : r + 1);
      end
      4: begin
        op = 8'(($urandom_range(0, 255)));
        while (op == 8'hEC || op == 8'hA0 || op == 8'hA1) op = 8'($urandom_range(0, 255));
        len = 4 + int'($urandom_range(0, 4));
      end
      default: begin
        op  = 8'hEC;
        len = int'($urandom_range(0, 3));
      end
    endcase
    p.push_back(op);
    p.push_back(8'($urandom_range(0, 255)));
    p.push_back(len[7:0]);
    p.push_back(len[15:8]);
    for (int i = 4; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
    return p;
  endfunction

  // Caller must be at posedge+1; returns at posedge+1 after the transfer edge
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard    = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready_o && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready_o) check_val("rx_ready_wait", 32'(rx_ready_o), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy_o && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (busy_o) check_val("idle_wait", 32'(busy_o), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run_packet(input string tag, input byte_q_t p, input bit check_busy_drop);
    byte_q_t exp;
    int exp_err;
    int tx_base;
    int err_base;
    ref_model(p, exp, exp_err);
    tx_base  = q_tx.size();
    err_base = err_total;
    foreach (p[i]) send_byte(p[i]);
    if (check_busy_drop) check_val({tag, "_busy_drop"}, 32'(busy_o), 32'd0);
    wait_idle();
    check_val({tag, "_nbytes"}, 32'(q_tx.size() - tx_base), 32'(exp.size()));
    for (int i = 0; i < exp.size() && (tx_base + i) < q_tx.size(); i++)
      check_val({tag, "_byte"}, 32'(q_tx[tx_base + i]), 32'(exp[i]));
    check_val({tag, "_err"}, 32'(err_total - err_base), 32'(exp_err));
    $display("pkt %s op=%02h len=%0d tx=%0d err=%0d", tag, p[0], int'({p[3], p[2]}),
             q_tx.size() - tx_base, err_total - err_base);
  endtask

  initial begin
    byte_q_t pkt;
    byte_q_t exp;
    int      exp_err;
    int      tx_base;
    int      bad_cycles;

    rst_n          = 1'b0;
    rx_valid       = 1'b0;
    rx_data        = 8'h00;
    bp_mode        = 1'b0;
    tx_ready_force = 1'b1;

    repeat (3) @(negedge clk);
    check_val("rst_rx_ready", 32'(rx_ready_o), 32'd0);
    check_val("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check_val("rst_tx_data", 32'(tx_data_o), 32'd0);
    check_val("rst_error", 32'(error_o), 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Echo with zero latency; busy drops with the last payload byte
    run_packet("echo", '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43}, 1'b1);
    // Add wrap and plain add
    run_packet("add_wrap", '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                             8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0);
    run_packet("add3", '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                         8'h02, 8'h00, 8'h00, 8'h00}, 1'b0);

    // Mul with tx backpressure on the first result byte
    pkt = '{8'hA1, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
            8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    ref_model(pkt, exp, exp_err);
    tx_base        = q_tx.size();
    tx_ready_force = 1'b0;
    foreach (pkt[i]) send_byte(pkt[i]);
    check_val("mul_send_latency", 32'(tx_valid_o), 32'd1);
    bad_cycles = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h00 || rx_ready_o !== 1'b0) bad_cycles++;
    end
    check_val("mul_hold_stable", 32'(bad_cycles), 32'd0);
    tx_ready_force = 1'b1;
    wait_idle();
    check_val("mul_nbytes", 32'(q_tx.size() - tx_base), 32'(exp.size()));
    for (int i = 0; i < exp.size() && (tx_base + i) < q_tx.size(); i++)
      check_val("mul_byte", 32'(q_tx[tx_base + i]), 32'(exp[i]));
    $display("pkt mul_bp op=a1 len=16 tx=%0d", q_tx.size() - tx_base);

    // Malformed packets
    run_packet("bad_len", '{8'hA0, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33}, 1'b0);
    run_packet("echo_after", '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A}, 1'b0);
    run_packet("unknown_op", '{8'h33, 8'h00, 8'h06, 8'h00, 8'hAB, 8'hCD}, 1'b0);
    run_packet("short_len", '{8'hA0, 8'h00, 8'h02, 8'h00}, 1'b0);
    run_packet("alu_empty", '{8'hA1, 8'h00, 8'h04, 8'h00}, 1'b0);

    // Reset in the middle of an add packet
    pkt = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22};
    foreach (pkt[i]) send_byte(pkt[i]);
    tx_base = q_tx.size();
    rst_n   = 1'b0;
    #1;
    check_val("midrst_rx_ready", 32'(rx_ready_o), 32'd0);
    check_val("midrst_tx_valid", 32'(tx_valid_o), 32'd0);
    check_val("midrst_tx_data", 32'(tx_data_o), 32'd0);
    check_val("midrst_busy", 32'(busy_o), 32'd0);
    check_val("midrst_error", 32'(error_o), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("midrst_no_tx", 32'(q_tx.size() - tx_base), 32'd0);
    @(posedge clk);
    #1;
    run_packet("echo_post_rst", '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h99}, 1'b0);

    // Randomized packets with random tx backpressure
    bp_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      pkt = make_random();
      run_packet($sformatf("rnd%0d", n), pkt, 1'b0);
    end
    bp_mode = 1'b0;
    tx_ready_force = 1'b1;
    wait_idle();

`ifdef CMD_TIMEOUT_EN
    begin
      int n_wait;
      int e_base;
      n_wait = 0;
      pkt    = '{8'hA0, 8'h00, 8'h08, 8'h00};
      foreach (pkt[i]) send_byte(pkt[i]);
      e_base = err_total;
      while (!error_o && n_wait < 1000) begin
        @(posedge clk);
        #1;
        n_wait++;
      end
      check_val("timeout_cycles", 32'(n_wait), 32'd100);
      check_val("timeout_busy", 32'(busy_o), 32'd0);
      wait_idle();
      check_val("timeout_err_pulses", 32'(err_total - e_base), 32'd1);
      run_packet("add_after_timeout", '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00,
                                        8'h08, 8'h00, 8'h00, 8'h00}, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
